// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer: op codes,
// default latencies and the countdown width helper.
package e_mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MdMult  = 3'd0,
        MdMultu = 3'd1,
        MdDiv   = 3'd2,
        MdDivu  = 3'd3,
        MdMthi  = 3'd4,
        MdMtlo  = 3'd5
    } md_op_e;

    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

    // Bits needed to hold the larger of the two latencies.
    function automatic int unsigned cnt_width(input int unsigned mult_n, input int unsigned div_n);
        int unsigned max_n;
        max_n = (mult_n > div_n) ? mult_n : div_n;
        return $clog2(max_n + 1);
    endfunction

    // md_op 0..3 are the multi-cycle arithmetic ops.
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage <-> multiply/divide unit signal bundle.
interface e_mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, a, b, md_use,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, md_use,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_timer.sv
// Loadable down-counter modelling multiply/divide latency; busy while non-zero,
// done on the final busy cycle.
module mdu_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             busy,
    output logic             done
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end else if (load) begin
            cnt_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == Width'(1));

endmodule

// File: rtl/e_mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; results are computed at
// issue, held pending, and committed when the latency countdown expires.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input logic         clk,
    input logic         reset,
    e_mdu_ctrl_if.slave md
);

    localparam int unsigned CntW = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

    logic        busy, done, accept, idle_op;
    logic [31:0] hi_d, hi_q, lo_d, lo_q;
    logic [31:0] pend_hi_d, pend_hi_q, pend_lo_d, pend_lo_q;
    logic        pend_wr_d, pend_wr_q;

    logic [63:0]        prod_s, prod_u;
    logic signed [63:0] sa64, sb64;
    logic [31:0]        b_safe, q_s, r_s, q_u, r_u;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;

    assign accept  = md.start & ~busy & is_arith(md.md_op);
    assign idle_op = md.start & ~busy;

    mdu_timer #(
        .Width(CntW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .load_val(md.md_op[1] ? DivLoad : MultLoad),
        .busy    (busy),
        .done    (done)
    );

    always_comb begin
        sa64   = {{32{md.a[31]}}, md.a};
        sb64   = {{32{md.b[31]}}, md.b};
        prod_s = sa64 * sb64;
        prod_u = {32'd0, md.a} * {32'd0, md.b};

        // Divisor forced non-zero so the dividers never see zero; result discarded then.
        b_safe = (md.b == 32'd0) ? 32'd1 : md.b;
        sa32   = $signed(md.a);
        sb32   = $signed(b_safe);
        if ((md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF)) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = sa32 / sb32;
            r_s = sa32 % sb32;
        end
        q_u = md.a / b_safe;
        r_u = md.a % b_safe;

        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        unique case (md.md_op[1:0])
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                res_hi = r_s;
                res_lo = q_s;
                res_wr = (md.b != 32'd0);
            end
            default: begin
                res_hi = r_u;
                res_lo = q_u;
                res_wr = (md.b != 32'd0);
            end
        endcase
    end

    always_comb begin
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (accept) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = res_wr;
        end

        if (done) begin
            if (pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
            pend_wr_d = 1'b0;
        end else if (idle_op && (md.md_op == MdMthi)) begin
            hi_d = md.a;
        end else if (idle_op && (md.md_op == MdMtlo)) begin
            lo_d = md.a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign md.busy      = busy;
    assign md.stall_req = md.md_use & (busy | (md.start & is_arith(md.md_op)));
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed self-checking bench for e_mdu_ctrl with hand-computed HI/LO results.
module tb_e_mdu_ctrl;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    e_mdu_ctrl_if md_if ();

    e_mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op for a single cycle, then verify busy/stall_req for n cycles
    // and busy low afterwards.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic use_i);
        md_if.start  = 1'b1;
        md_if.md_op  = op;
        md_if.a      = a;
        md_if.b      = b;
        md_if.md_use = use_i;
        #1;
        check({tag, " stall_issue"}, {31'd0, md_if.stall_req}, {31'd0, use_i});
        tick();
        md_if.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, " busy"}, {31'd0, md_if.busy}, 32'd1);
            check({tag, " stall_busy"}, {31'd0, md_if.stall_req}, {31'd0, use_i});
            tick();
        end
        #1;
        check({tag, " busy_done"}, {31'd0, md_if.busy}, 32'd0);
        check({tag, " stall_done"}, {31'd0, md_if.stall_req}, 32'd0);
        md_if.md_use = 1'b0;
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
        md_if.start = 1'b1;
        md_if.md_op = op;
        md_if.a     = a;
        md_if.b     = 32'd0;
        tick();
        md_if.start = 1'b0;
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        md_if.start  = 1'b0;
        md_if.md_op  = 3'd0;
        md_if.a      = 32'd0;
        md_if.b      = 32'd0;
        md_if.md_use = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset busy", {31'd0, md_if.busy}, 32'd0);
        check("reset hi", md_if.hi, 32'd0);
        check("reset lo", md_if.lo, 32'd0);
        check("reset stall", {31'd0, md_if.stall_req}, 32'd0);

        // MULT -2 * 3 with md_use held high
        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 1'b1);
        check("mult hi", md_if.hi, 32'hFFFF_FFFF);
        check("mult lo", md_if.lo, 32'hFFFF_FFFA);

        // MULTU 0x10000 * 0x10000 with md_use low
        run_op("multu", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 1'b0);
        check("multu hi", md_if.hi, 32'd1);
        check("multu lo", md_if.lo, 32'd0);

        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        check("div hi", md_if.hi, 32'hFFFF_FFFF);
        check("div lo", md_if.lo, 32'hFFFF_FFFD);

        run_op("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 1'b0);
        check("div_negb hi", md_if.hi, 32'd1);
        check("div_negb lo", md_if.lo, 32'hFFFF_FFFD);

        run_op("divu", 3'd3, 32'd7, 32'd2, 10, 1'b1);
        check("divu hi", md_if.hi, 32'd1);
        check("divu lo", md_if.lo, 32'd3);

        run_op("divu_big", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        check("divu_big hi", md_if.hi, 32'd1);
        check("divu_big lo", md_if.lo, 32'h7FFF_FFFC);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        check("div_ovf hi", md_if.hi, 32'd0);
        check("div_ovf lo", md_if.lo, 32'h8000_0000);

        // Preload HI/LO then divide by zero
        mt_op(3'd4, 32'h11);
        #1;
        check("mthi hi", md_if.hi, 32'h11);
        check("mthi lo", md_if.lo, 32'h8000_0000);
        check("mthi busy", {31'd0, md_if.busy}, 32'd0);
        mt_op(3'd5, 32'h22);
        #1;
        check("mtlo hi", md_if.hi, 32'h11);
        check("mtlo lo", md_if.lo, 32'h22);
        run_op("divu0", 3'd3, 32'd99, 32'd0, 10, 1'b0);
        check("divu0 hi", md_if.hi, 32'h11);
        check("divu0 lo", md_if.lo, 32'h22);
        run_op("div0", 3'd2, 32'd99, 32'd0, 10, 1'b0);
        check("div0 hi", md_if.hi, 32'h11);
        check("div0 lo", md_if.lo, 32'h22);

        mt_op(3'd5, 32'hDEAD_BEEF);
        #1;
        check("mtlo2 lo", md_if.lo, 32'hDEAD_BEEF);
        check("mtlo2 hi", md_if.hi, 32'h11);
        check("mtlo2 busy", {31'd0, md_if.busy}, 32'd0);

        // Reserved op codes change nothing
        md_if.md_use = 1'b1;
        md_if.start  = 1'b1;
        md_if.md_op  = 3'd7;
        md_if.a      = 32'h1234_5678;
        #1;
        check("rsvd stall", {31'd0, md_if.stall_req}, 32'd0);
        tick();
        md_if.md_op = 3'd6;
        tick();
        md_if.start  = 1'b0;
        md_if.md_use = 1'b0;
        #1;
        check("rsvd busy", {31'd0, md_if.busy}, 32'd0);
        check("rsvd hi", md_if.hi, 32'h11);
        check("rsvd lo", md_if.lo, 32'hDEAD_BEEF);

        // Second MULT and an MTHI while busy are both ignored
        md_if.start = 1'b1;
        md_if.md_op = 3'd0;
        md_if.a     = 32'd3;
        md_if.b     = 32'd4;
        tick();
        md_if.a = 32'd5;
        md_if.b = 32'd5;
        tick();
        md_if.md_op = 3'd4;
        md_if.a     = 32'hAAAA_AAAA;
        tick();
        md_if.start = 1'b0;
        tick();
        tick();
        #1;
        check("ovl busy5", {31'd0, md_if.busy}, 32'd1);
        check("ovl hi_mid", md_if.hi, 32'h11);
        tick();
        #1;
        check("ovl busy6", {31'd0, md_if.busy}, 32'd0);
        check("ovl hi", md_if.hi, 32'd0);
        check("ovl lo", md_if.lo, 32'd12);
        tick();
        #1;
        check("ovl busy7", {31'd0, md_if.busy}, 32'd0);
        check("ovl lo7", md_if.lo, 32'd12);

        // Reset asserted in cycle 3 of a DIV
        md_if.start = 1'b1;
        md_if.md_op = 3'd2;
        md_if.a     = 32'd100;
        md_if.b     = 32'd7;
        tick();
        md_if.start = 1'b0;
        tick();
        tick();
        #1;
        check("rstmid busy3", {31'd0, md_if.busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rstmid busy", {31'd0, md_if.busy}, 32'd0);
        check("rstmid hi", md_if.hi, 32'd0);
        check("rstmid lo", md_if.lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        #1;
        check("rstmid late busy", {31'd0, md_if.busy}, 32'd0);
        check("rstmid late hi", md_if.hi, 32'd0);
        check("rstmid late lo", md_if.lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
